// File: rtl/serial_paralelo_rx_if.sv
// Lane receive interface: serial bit in, recovered byte stream out.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  // Serializer / stimulus side: drives the serial bit, observes recovered bytes.
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  // Receiver side.
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel lane receiver: shifts in MSB-first bits, aligns on the idle
// symbol, locks after BC_COUNT aligned idles and then presents each data byte.
module serial_paralelo_rx #(
  parameter logic [7:0]  IDLE_SYM = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  lane
);

  typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_e;

  localparam logic [3:0] BcTarget = 4'(BC_COUNT);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] nxt;
  logic       boundary;
  logic       is_idle;

  // Next-state: alignment search, idle counting and byte presentation.
  always_comb begin
    nxt      = {sr_q[6:0], lane.data_in};
    boundary = (bit_cnt_q == 3'd7);
    is_idle  = (nxt == IDLE_SYM);

    sr_d      = nxt;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    unique case (state_q)
      StSearch: begin
        // Bit-slip search: any cycle may start an alignment.
        if (is_idle) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = (BcTarget == 4'd1) ? StLocked : StAlign;
        end
      end
      StAlign: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_idle) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == BcTarget) begin
              state_d = StLocked;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = StSearch;
          end
        end
      end
      StLocked: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_idle) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StSearch;
    endcase

    active_d = (state_d == StLocked);
  end

  // State and registered outputs; reset returns everything to search.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: two lanes (BC_COUNT=4 and BC_COUNT=1) share one bit
// stream; a bit-position model is checked every cycle, plus literal expectations.
module tb_serial_paralelo_rx;

  localparam logic [7:0] IDLE = 8'hBC;

  logic clk;
  logic rst;
  logic din;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  serial_paralelo_rx_if if_a ();
  serial_paralelo_rx_if if_b ();

  assign if_a.data_in = din;
  assign if_b.data_in = din;

  serial_paralelo_rx #(.IDLE_SYM(8'hBC), .BC_COUNT(4)) u_dut_a (
    .clk_32f (clk),
    .reset   (rst),
    .lane    (if_a)
  );

  serial_paralelo_rx #(.IDLE_SYM(8'hBC), .BC_COUNT(1)) u_dut_b (
    .clk_32f (clk),
    .reset   (rst),
    .lane    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: tracks the absolute bit index at which alignment was found; byte
  // boundaries are every 8th bit counted from there.
  typedef struct {
    logic [7:0] w;
    int         n;
    int         align_pos;
    int         idles;
    bit         locked;
    bit         strobe;
    logic [7:0] data;
    bit         valid;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.w = 8'h00; m.n = 0; m.align_pos = -1; m.idles = 0;
    m.locked = 1'b0; m.strobe = 1'b0; m.data = 8'h00; m.valid = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t mi, logic b, int need);
    model_t m = mi;
    bit on_b;
    m.w      = {m.w[6:0], b};
    m.n      = m.n + 1;
    m.strobe = 1'b0;
    on_b     = (m.align_pos >= 0) && (((m.n - m.align_pos) % 8) == 0);
    if (m.locked) begin
      if (on_b) begin
        m.strobe = 1'b1;
        if (m.w == IDLE) m.valid = 1'b0;
        else begin
          m.data  = m.w;
          m.valid = 1'b1;
        end
      end
    end else if (m.align_pos < 0) begin
      if (m.w == IDLE) begin
        m.align_pos = m.n;
        m.idles     = 1;
        m.locked    = (need == 1);
      end
    end else if (on_b) begin
      if (m.w == IDLE) begin
        m.idles = m.idles + 1;
        if (m.idles == need) m.locked = 1'b1;
      end else begin
        m.align_pos = -1;
        m.idles     = 0;
      end
    end
    return m;
  endfunction

  model_t ma, mb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, din, 4);
      mb <= model_step(mb, din, 1);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [7:0] dut_v, input logic [7:0] mod_v,
                     input logic [7:0] exp_v);
    check({name, " dut"}, dut_v, exp_v);
    check({name, " model"}, mod_v, exp_v);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("A active", {7'd0, if_a.active}, {7'd0, ma.locked});
      check("A valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid});
      check("A strobe", {7'd0, if_a.byte_strobe}, {7'd0, ma.strobe});
      check("A data", if_a.data_out, ma.data);
      check("B active", {7'd0, if_b.active}, {7'd0, mb.locked});
      check("B valid", {7'd0, if_b.valid_out}, {7'd0, mb.valid});
      check("B strobe", {7'd0, if_b.byte_strobe}, {7'd0, mb.strobe});
      check("B data", if_b.data_out, mb.data);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic lit_all_zero(input string tag);
    lit({tag, " A active"}, {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    lit({tag, " A valid"}, {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h00);
    lit({tag, " A data"}, if_a.data_out, ma.data, 8'h00);
    check({tag, " A strobe"}, {7'd0, if_a.byte_strobe}, 8'h00);
    check({tag, " B active"}, {7'd0, if_b.active}, 8'h00);
    check({tag, " B valid"}, {7'd0, if_b.valid_out}, 8'h00);
    check({tag, " B data"}, if_b.data_out, 8'h00);
  endtask

  initial begin
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit_all_zero("reset");
    @(negedge clk);
    #2 rst = 1'b0;

    // 1: idle line of zeros never locks or produces output.
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    lit_all_zero("zeros");

    // 2: garbage, 4 idles, A5, then an idle.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    lit("t2 A active 3bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    lit("t2 B active", {7'd0, if_b.active}, {7'd0, mb.locked}, 8'h01);
    send_byte(IDLE);
    lit("t2 A active 4bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h01);
    lit("t2 A valid 4bc", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h00);
    send_byte(8'hA5);
    lit("t2 A data", if_a.data_out, ma.data, 8'hA5);
    lit("t2 A valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);
    lit("t2 A strobe", {7'd0, if_a.byte_strobe}, {7'd0, ma.strobe}, 8'h01);
    lit("t2 B data", if_b.data_out, mb.data, 8'hA5);
    send_bit(IDLE[7]);
    lit("t2 A strobe low", {7'd0, if_a.byte_strobe}, {7'd0, ma.strobe}, 8'h00);
    lit("t2 A valid held", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);
    for (int i = 6; i >= 0; i--) send_bit(IDLE[i]);
    lit("t2 A valid idle", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h00);
    lit("t2 A data held", if_a.data_out, ma.data, 8'hA5);

    // 3: broken alignment drops back to search, then relock.
    reset_pulse();
    send_byte(IDLE);
    send_byte(IDLE);
    send_byte(8'h3C);
    lit("t3 A active drop", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    lit("t3 A valid drop", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h00);
    lit("t3 A data drop", if_a.data_out, ma.data, 8'h00);
    lit("t3 B data", if_b.data_out, mb.data, 8'h3C);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    lit("t3 A active 3bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    send_byte(IDLE);
    lit("t3 A active 4bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h01);
    send_byte(8'h11);
    lit("t3 A data", if_a.data_out, ma.data, 8'h11);
    lit("t3 A valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);

    // 4: locked stream with an idle in the middle.
    send_byte(8'hFF);
    lit("t4 FF data", if_a.data_out, ma.data, 8'hFF);
    lit("t4 FF valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);
    send_byte(8'h00);
    lit("t4 00 data", if_a.data_out, ma.data, 8'h00);
    lit("t4 00 valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);
    send_byte(IDLE);
    lit("t4 BC data", if_a.data_out, ma.data, 8'h00);
    lit("t4 BC valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h00);
    lit("t4 BC strobe", {7'd0, if_a.byte_strobe}, {7'd0, ma.strobe}, 8'h01);
    send_byte(8'h7E);
    lit("t4 7E data", if_a.data_out, ma.data, 8'h7E);
    lit("t4 7E valid", {7'd0, if_a.valid_out}, {7'd0, ma.valid}, 8'h01);

    // 5: reset mid-byte while locked; outputs clear before the next edge.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    lit_all_zero("t5 async");
    @(posedge clk);
    #1;
    @(negedge clk);
    #2 rst = 1'b0;
    send_byte(IDLE);
    // 6: BC_COUNT=1 lane locks on the first idle.
    lit("t6 B active", {7'd0, if_b.active}, {7'd0, mb.locked}, 8'h01);
    lit("t5 A active 1bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    send_byte(IDLE);
    send_byte(IDLE);
    lit("t5 A active 3bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h00);
    send_byte(IDLE);
    lit("t5 A active 4bc", {7'd0, if_a.active}, {7'd0, ma.locked}, 8'h01);
    send_byte(8'h5A);
    lit("t5 A data", if_a.data_out, ma.data, 8'h5A);
    lit("t6 B data", if_b.data_out, mb.data, 8'h5A);
    lit("t6 B valid", {7'd0, if_b.valid_out}, {7'd0, mb.valid}, 8'h01);

    repeat (4) send_bit(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
